// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch-resolution slice.
package btb_pkg;

  localparam int BTB_XLEN = 32;

  // Sequential fetch increment.
  localparam logic [BTB_XLEN-1:0] PC_STEP = BTB_XLEN'(4);

  // Prediction metadata carried from the IF lookup down to EX.
  typedef struct packed {
    logic                v;
    logic [BTB_XLEN-1:0] pc;
    logic                ptaken;
    logic [BTB_XLEN-1:0] ptarget;
  } btb_meta_t;

  // A branch mispredicts on a direction mismatch, or on a target mismatch
  // when it is taken. A non-branch mispredicts only when it was predicted taken
  // (a false BTB hit); it is treated as not taken.
  function automatic logic btb_mispredict(
    input btb_meta_t           meta,
    input logic                is_br,
    input logic                taken,
    input logic [BTB_XLEN-1:0] tgt
  );
    logic mis;
    if (is_br) begin
      mis = (meta.ptaken != taken) | (taken & (meta.ptarget != tgt));
    end else begin
      mis = meta.ptaken;
    end
    return mis;
  endfunction

endpackage

// File: rtl/btb_meta_pipe.sv
// DEPTH-stage shift register carrying BTB prediction metadata from IF to EX.
// Stall holds every stage; flush invalidates every stage, including the one
// being loaded from IF on the same edge.
module btb_meta_pipe
  import btb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_stall,
  input  logic      i_flush,
  input  btb_meta_t i_meta,
  output btb_meta_t o_ex
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      btb_meta_t r_stage;
      btb_meta_t w_src;

      if (gi == 0) begin : g_head
        assign w_src = i_meta;
      end else begin : g_body
        assign w_src = g_stage[gi-1].r_stage;
      end

      // Stage register: reset/flush kill the entry, otherwise shift unless stalled.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_stage <= '0;
        end else if (i_flush) begin
          r_stage   <= w_src;
          r_stage.v <= 1'b0;
        end else if (!i_stall) begin
          r_stage <= w_src;
        end
      end
    end
  endgenerate

  // The last stage is the instruction currently in EX.
  assign o_ex = g_stage[DEPTH-1].r_stage;

endmodule

// File: rtl/btb_resolve.sv
// EX-stage branch resolution: compares the carried BTB prediction with the
// actual outcome, drives the BTB write port, fetch redirect/flush and
// saturating statistics counters. All outputs are registered (1-cycle latency).
// XLEN must match btb_pkg::BTB_XLEN, which sizes the metadata struct.
module btb_resolve
  import btb_pkg::*;
#(
  parameter int XLEN  = BTB_XLEN,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             btb_valid,
  input  logic             btb_taken,
  input  logic [XLEN-1:0]  btb_target,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             update,
  output logic [XLEN-1:0]  updatePC,
  output logic [XLEN-1:0]  updateTarget,
  output logic             mispredicted,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  btb_meta_t        w_if_meta;
  btb_meta_t        w_ex;
  logic             w_resolve;
  logic             w_false_hit;
  logic             w_taken;
  logic             w_mis;
  logic             w_flush;
  logic             w_upd;
  logic [XLEN-1:0]  w_pc_seq;
  logic [XLEN-1:0]  w_npc;

  logic             r_update;
  logic [XLEN-1:0]  r_upd_pc;
  logic [XLEN-1:0]  r_upd_tgt;
  logic             r_mispred;
  logic             r_redirect;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mis_count;

  // A prediction counts as taken only on a BTB hit.
  assign w_if_meta.v       = if_valid;
  assign w_if_meta.pc      = if_pc;
  assign w_if_meta.ptaken  = btb_valid & btb_taken;
  assign w_if_meta.ptarget = btb_target;

  btb_meta_pipe #(
    .DEPTH (DEPTH)
  ) u_meta_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_stall (stall),
    .i_flush (w_flush),
    .i_meta  (w_if_meta),
    .o_ex    (w_ex)
  );

  // Resolution compare; a stalled EX instruction is never resolved.
  always_comb begin
    w_resolve   = w_ex.v & ~stall;
    w_false_hit = ~ex_is_branch & w_ex.ptaken;
    w_taken     = ex_is_branch & ex_taken;
    w_pc_seq    = w_ex.pc + PC_STEP;
    w_npc       = w_taken ? ex_target : w_pc_seq;
    w_mis       = btb_mispredict(w_ex, ex_is_branch, ex_taken, ex_target);
    w_flush     = w_resolve & w_mis;
    w_upd       = w_resolve & (ex_is_branch | w_false_hit);
  end

  // Output registers: 1-bit pulses follow each cycle, wide data holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_update      <= 1'b0;
      r_upd_pc      <= '0;
      r_upd_tgt     <= '0;
      r_mispred     <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_update   <= w_upd;
      r_mispred  <= w_flush;
      r_redirect <= w_flush;
      if (w_upd) begin
        r_upd_pc  <= w_ex.pc;
        r_upd_tgt <= w_npc;
      end
      if (w_flush) begin
        r_redirect_pc <= w_npc;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_count  <= '0;
      r_mis_count <= '0;
    end else begin
      if (w_resolve && ex_is_branch && (r_br_count != '1)) begin
        r_br_count <= r_br_count + CNT_ONE;
      end
      if (w_flush && (r_mis_count != '1)) begin
        r_mis_count <= r_mis_count + CNT_ONE;
      end
    end
  end

  assign update        = r_update;
  assign updatePC      = r_upd_pc;
  assign updateTarget  = r_upd_tgt;
  assign mispredicted  = r_mispred;
  assign redirect      = r_redirect;
  assign flush         = r_redirect;
  assign redirect_pc   = r_redirect_pc;
  assign br_count      = r_br_count;
  assign mispred_count = r_mis_count;

endmodule
